// File: rtl/cve2_pkg.sv
// ---------------------------------------------------------------------------
// cve2_pkg: shared MUL/DIV operator encoding and issue-stage FSM types. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cve2_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_ISSUE_IDLE  = 2'b00,
        MD_ISSUE_BUSY  = 2'b01,
        MD_ISSUE_DRAIN = 2'b10,
        MD_ISSUE_RESP  = 2'b11
    } md_issue_state_e;

    // Worst-case divide latency of the multiplier/divider, in cycles.
    localparam int unsigned MD_ISSUE_MAX_LAT = 37;

    function automatic logic md_op_is_mult(input md_op_e op);
        return (op == MD_OP_MULL) || (op == MD_OP_MULH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cve2_multdiv_result_cache.sv
// ---------------------------------------------------------------------------
// cve2_multdiv_result_cache: single-entry MUL/DIV result cache, built only
// when CVE2_MULTDIV_RESULT_CACHE_EN is defined.                     Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifdef CVE2_MULTDIV_RESULT_CACHE_EN
module cve2_multdiv_result_cache
    import cve2_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  md_op_e      lookup_op_i,
    input  logic [1:0]  lookup_signed_mode_i,
    input  logic [31:0] lookup_a_i,
    input  logic [31:0] lookup_b_i,
    output logic        hit_o,
    output logic [31:0] hit_result_o,
    input  logic        fill_i,
    input  md_op_e      fill_op_i,
    input  logic [1:0]  fill_signed_mode_i,
    input  logic [31:0] fill_a_i,
    input  logic [31:0] fill_b_i,
    input  logic [31:0] fill_result_i
);

    logic        valid_q;
    md_op_e      op_q;
    logic [1:0]  signed_mode_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] result_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q       <= 1'b0;
            op_q          <= MD_OP_MULL;
            signed_mode_q <= 2'b00;
            a_q           <= '0;
            b_q           <= '0;
            result_q      <= '0;
        end else if (fill_i) begin
            valid_q       <= 1'b1;
            op_q          <= fill_op_i;
            signed_mode_q <= fill_signed_mode_i;
            a_q           <= fill_a_i;
            b_q           <= fill_b_i;
            result_q      <= fill_result_i;
        end
    end

    assign hit_o = valid_q
                && (lookup_op_i == op_q)
                && (lookup_signed_mode_i == signed_mode_q)
                && (lookup_a_i == a_q)
                && (lookup_b_i == b_q);

    assign hit_result_o = result_q;

endmodule
`endif

`default_nettype wire

// File: rtl/cve2_multdiv_issue.sv
// ---------------------------------------------------------------------------
// cve2_multdiv_issue: issue/response stage in front of the slow MUL/DIV unit.
// Optional result cache: CVE2_MULTDIV_RESULT_CACHE_EN.              Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cve2_multdiv_issue
    import cve2_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 48
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [1:0]  req_signed_mode_i,
    input  logic [31:0] req_op_a_i,
    input  logic [31:0] req_op_b_i,
    input  logic        flush_i,
    output logic        md_mult_en_o,
    output logic        md_div_en_o,
    output logic        md_mult_sel_o,
    output logic        md_div_sel_o,
    output logic [1:0]  md_operator_o,
    output logic [1:0]  md_signed_mode_o,
    output logic [31:0] md_op_a_o,
    output logic [31:0] md_op_b_o,
    output logic        md_ready_id_o,
    input  logic        md_valid_i,
    input  logic [31:0] md_result_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic        busy_o,
    output logic        timeout_o
);

    localparam int unsigned      CNT_W   = $clog2(TimeoutCycles);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TimeoutCycles - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TimeoutCycles - 2);

    md_issue_state_e state_q;
    md_issue_state_e state_d;
    md_op_e          op_q;
    md_op_e          op_d;
    md_op_e          req_op;
    logic [1:0]      signed_mode_q;
    logic [31:0]     op_a_q;
    logic [31:0]     op_b_q;
    logic [31:0]     result_q;
    logic [CNT_W-1:0] wd_cnt_q;
    logic            timeout_q;
    logic            mult_en_q;
    logic            div_en_q;
    logic            ready_id_q;
    logic            rsp_valid_q;
    logic            req_ready_q;
    logic            busy_q;

    logic            accept;
    logic            capture;
    logic            in_md;
    logic            in_md_d;
    logic            cache_hit;
    logic [31:0]     cache_result;

    assign req_op  = md_op_e'(req_op_i);
    assign accept  = (state_q == MD_ISSUE_IDLE) && req_valid_i;
    assign capture = (state_q == MD_ISSUE_BUSY) && md_valid_i && !flush_i;
    assign in_md   = (state_q == MD_ISSUE_BUSY) || (state_q == MD_ISSUE_DRAIN);
    assign in_md_d = (state_d == MD_ISSUE_BUSY) || (state_d == MD_ISSUE_DRAIN);
    assign op_d    = accept ? req_op : op_q;

`ifdef CVE2_MULTDIV_RESULT_CACHE_EN
    cve2_multdiv_result_cache u_result_cache (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .lookup_op_i          (req_op),
        .lookup_signed_mode_i (req_signed_mode_i),
        .lookup_a_i           (req_op_a_i),
        .lookup_b_i           (req_op_b_i),
        .hit_o                (cache_hit),
        .hit_result_o         (cache_result),
        .fill_i               (capture),
        .fill_op_i            (op_q),
        .fill_signed_mode_i   (signed_mode_q),
        .fill_a_i             (op_a_q),
        .fill_b_i             (op_b_q),
        .fill_result_i        (md_result_i)
    );
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_ISSUE_IDLE: begin
                if (req_valid_i) begin
                    state_d = cache_hit ? MD_ISSUE_RESP : MD_ISSUE_BUSY;
                end
            end
            MD_ISSUE_BUSY: begin
                if (md_valid_i && flush_i) begin
                    state_d = MD_ISSUE_IDLE;
                end else if (md_valid_i) begin
                    state_d = MD_ISSUE_RESP;
                end else if (flush_i) begin
                    state_d = MD_ISSUE_DRAIN;
                end
            end
            // Enables stay up until the unit finishes, so its FSM ends in idle.
            MD_ISSUE_DRAIN: begin
                if (md_valid_i) begin
                    state_d = MD_ISSUE_IDLE;
                end
            end
            MD_ISSUE_RESP: begin
                if (rsp_ready_i || flush_i) begin
                    state_d = MD_ISSUE_IDLE;
                end
            end
            default: state_d = MD_ISSUE_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= MD_ISSUE_IDLE;
            op_q          <= MD_OP_MULL;
            signed_mode_q <= 2'b00;
            op_a_q        <= '0;
            op_b_q        <= '0;
            result_q      <= '0;
            wd_cnt_q      <= '0;
            timeout_q     <= 1'b0;
            mult_en_q     <= 1'b0;
            div_en_q      <= 1'b0;
            ready_id_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                op_q          <= req_op;
                signed_mode_q <= req_signed_mode_i;
                op_a_q        <= req_op_a_i;
                op_b_q        <= req_op_b_i;
            end

            if (capture) begin
                result_q <= md_result_i;
            end else if (accept && cache_hit) begin
                result_q <= cache_result;
            end

            // Watchdog saturates, so the pulse fires only on the first arrival.
            if (accept && (state_d == MD_ISSUE_BUSY)) begin
                wd_cnt_q <= '0;
            end else if (in_md && (wd_cnt_q != CNT_MAX)) begin
                wd_cnt_q <= wd_cnt_q + CNT_W'(1);
            end
            timeout_q <= in_md && (wd_cnt_q == CNT_PRE);

            mult_en_q   <= in_md_d && md_op_is_mult(op_d);
            div_en_q    <= in_md_d && !md_op_is_mult(op_d);
            ready_id_q  <= in_md_d;
            rsp_valid_q <= (state_d == MD_ISSUE_RESP);
            req_ready_q <= (state_d == MD_ISSUE_IDLE);
            busy_q      <= (state_d != MD_ISSUE_IDLE);
        end
    end

    assign req_ready_o      = req_ready_q;
    assign md_mult_en_o     = mult_en_q;
    assign md_mult_sel_o    = mult_en_q;
    assign md_div_en_o      = div_en_q;
    assign md_div_sel_o     = div_en_q;
    assign md_operator_o    = op_q;
    assign md_signed_mode_o = signed_mode_q;
    assign md_op_a_o        = op_a_q;
    assign md_op_b_o        = op_b_q;
    assign md_ready_id_o    = ready_id_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_result_o     = result_q;
    assign busy_o           = busy_q;
    assign timeout_o        = timeout_q;

endmodule

`default_nettype wire
